// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_arbiter_pkg: state encodings and sizing helpers          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_tx_arbiter_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRANT  = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  // Idle-timeout counter width; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_arbiter_rr_pick: round-robin select, first request at or |
// | above the pointer with wrap. Rev 1.0                              |
// +------------------------------------------------------------------+
module uart_tx_arbiter_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_onehot,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);

  localparam int c_idx_w = $clog2(NREQ);

  logic [c_idx_w-1:0] w_pos [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_pos
    assign w_pos[k] = c_idx_w'((int'(i_ptr) + k) % NREQ);
  end

  // Scan from farthest offset down so the nearest request wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[w_pos[k]]) begin
        o_idx = w_pos[k];
        o_any = 1'b1;
      end
    end
    o_onehot[o_idx] = o_any;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_arbiter: message-granular round-robin sharing of the     |
// | fifo_uart transmit port with idle timeout. Rev 1.0                |
// +------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              uart_wr,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_busy
);

  localparam int c_idx_w = $clog2(NREQ);
  localparam int c_cnt_w = cnt_width(TIMEOUT_CYCLES);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NREQ - 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [2:0]         r_state, w_state_nxt;
  logic [NREQ-1:0]    r_grant, w_grant_nxt;
  logic [c_idx_w-1:0] r_gidx, w_gidx_nxt;
  logic [c_idx_w-1:0] r_ptr, w_ptr_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]         r_byte, w_byte_nxt;
  logic               r_last, w_last_nxt;
  logic [NREQ-1:0]    r_ready, w_ready_nxt;
  logic               r_wr, w_wr_nxt;

  logic [NREQ-1:0]    w_pick_onehot;
  logic [c_idx_w-1:0] w_pick_idx;
  logic               w_pick_any;
  logic               w_accept, w_release;
  logic               w_req_g, w_valid_g, w_last_g;
  logic [7:0]         w_data_g;
  logic [c_idx_w-1:0] w_ptr_after;

  uart_tx_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_req_g     = req[r_gidx];
  assign w_valid_g   = req_valid[r_gidx];
  assign w_last_g    = req_last[r_gidx];
  assign w_data_g    = req_data[8*r_gidx +: 8];
  // Releasing owner drops to lowest priority.
  assign w_ptr_after = (r_gidx == c_last_idx) ? '0 : r_gidx + c_idx_w'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_byte  <= '0;
      r_last  <= 1'b0;
      r_ready <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_byte  <= w_byte_nxt;
      r_last  <= w_last_nxt;
      r_ready <= w_ready_nxt;
      r_wr    <= w_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: if (w_pick_any) w_state_nxt = S_GRANT;
      S_GRANT: begin
        if (w_valid_g && !uart_busy) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WRITE;
        end else if (!w_req_g || (r_cnt == c_tmo_last)) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE:  w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!uart_busy) begin
          if (r_last || !w_req_g) begin
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GRANT;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_byte_nxt  = r_byte;
    w_last_nxt  = r_last;
    w_ready_nxt = '0;
    w_wr_nxt    = 1'b0;
    if (r_state == S_IDLE && w_pick_any) begin
      w_grant_nxt = w_pick_onehot;
      w_gidx_nxt  = w_pick_idx;
      w_cnt_nxt   = '0;
    end
    if (r_state == S_GRANT && !w_accept && !w_release)
      w_cnt_nxt = r_cnt + c_cnt_w'(1);
    if (r_state == S_DRAIN && w_state_nxt == S_GRANT)
      w_cnt_nxt = '0;
    // Byte, ready pulse and write strobe all launch on the same edge.
    if (w_accept) begin
      w_byte_nxt  = w_data_g;
      w_last_nxt  = w_last_g;
      w_ready_nxt = r_grant;
      w_wr_nxt    = 1'b1;
    end
    if (w_release) begin
      w_grant_nxt = '0;
      w_ptr_nxt   = w_ptr_after;
    end
  end

  assign req_ready    = r_ready;
  assign grant        = r_grant;
  assign uart_wr      = r_wr;
  assign uart_tx_data = r_byte;

endmodule
`default_nettype wire
